// File: rtl/random_digit_gen_if.sv
// Bus bundle for random_digit_gen: seed control, draw request and result.
// Handshake: req is a level sampled only while the generator is idle (and
// seed_load is low); there is no ready back-pressure. Each accepted req
// produces exactly one rnd_valid pulse unless the draw is aborted by
// seed_load or reset. rnd is stable from that pulse until the next one.
// timeout pulses together with rnd_valid when the draw ran out of tries.
interface random_digit_gen_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 4
) ();
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              req;
  logic [OUT_W-1:0]  rnd;
  logic              rnd_valid;
  logic              busy;
  logic              timeout;

  modport master (
    output seed_load, seed_in, req,
    input  rnd, rnd_valid, busy, timeout
  );

  modport slave (
    input  seed_load, seed_in, req,
    output rnd, rnd_valid, busy, timeout
  );
endinterface

// File: rtl/random_digit_gen.sv
// Rejection-sampling digit generator. A free-running Fibonacci LFSR supplies
// one candidate per DRAW cycle; candidates outside [MIN_VAL, MAX_VAL] are
// rejected until one fits or MAX_TRIES candidates have been consumed, in
// which case MIN_VAL is returned and timeout is flagged.
// state_o and lfsr_o expose the FSM state and LFSR contents for observation.
module random_digit_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                OUT_W     = 4,
  parameter int                MIN_VAL   = 1,
  parameter int                MAX_VAL   = 9,
  parameter int                MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  random_digit_gen_if.slave  bus,
  output logic [0:0]         state_o,
  output logic [LFSR_W-1:0]  lfsr_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DRAW = 1'b1;

  // One extra bit so the counter can never wrap inside a draw.
  localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W-1:0] MIN_C    = OUT_W'(MIN_VAL);
  localparam logic [OUT_W-1:0] MAX_C    = OUT_W'(MAX_VAL);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [0:0]        state_q, state_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [OUT_W-1:0]  rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              busy_q;
  logic [OUT_W-1:0]  candidate;
  logic              cand_ok;

  assign candidate = lfsr_q[OUT_W-1:0];
  assign cand_ok   = (candidate >= MIN_C) && (candidate <= MAX_C);

  // LFSR next state: shift every cycle; a seed load replaces the shift and a
  // zero seed is swapped for SEED so the lock-up state is unreachable.
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    if (bus.seed_load) begin
      lfsr_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
    end
  end

  // Draw FSM: accept, retry or give up on each DRAW cycle; seed_load aborts.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    rnd_d     = rnd_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.seed_load && bus.req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (bus.seed_load) begin
          state_d = IDLE;
        end else if (cand_ok) begin
          rnd_d   = candidate;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (tries_q == LAST_TRY) begin
          rnd_d     = MIN_C;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset to the seeded idle condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= SEED;
      state_q   <= IDLE;
      tries_q   <= '0;
      rnd_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      state_q   <= state_d;
      tries_q   <= tries_d;
      rnd_q     <= rnd_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == DRAW);
    end
  end

  assign bus.rnd       = rnd_q;
  assign bus.rnd_valid = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;
  assign state_o       = state_q;
  assign lfsr_o        = lfsr_q;

endmodule

// File: tb/tb_random_digit_gen.sv
// Directed bench for random_digit_gen. Two instances share all inputs:
// dut_a uses default parameters, dut_b uses MAX_TRIES=1.
module tb_random_digit_gen;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic [0:0]  state_a, state_b;
  logic [15:0] lfsr_a, lfsr_b;

  int checks;
  int failures;

  random_digit_gen_if if_a ();
  random_digit_gen_if if_b ();

  assign if_a.seed_load = seed_load;
  assign if_a.seed_in   = seed_in;
  assign if_a.req       = req;
  assign if_b.seed_load = seed_load;
  assign if_b.seed_in   = seed_in;
  assign if_b.req       = req;

  random_digit_gen dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if_a),
    .state_o (state_a),
    .lfsr_o  (lfsr_a)
  );

  random_digit_gen #(.MAX_TRIES(1)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if_b),
    .state_o (state_b),
    .lfsr_o  (lfsr_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          lat;
    int          zero_seen;
    int          first_ret;
    logic [15:0] step1;
    int          draws;
    int          cyc;
    logic        prev_valid;
    logic [15:0] seen;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    seed_load = 1'b0;
    seed_in   = 16'h0;
    req       = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #2;
    check("rst_rnd",     if_a.rnd, 0);
    check("rst_busy",    if_a.busy, 0);
    check("rst_valid",   if_a.rnd_valid, 0);
    check("rst_timeout", if_a.timeout, 0);
    check("rst_lfsr",    lfsr_a, 16'hACE1);
    check("rst_state",   state_a, 0);
    tick();
    tick();
    check("rst_hold_lfsr", lfsr_a, 16'hACE1);
    rst_n = 1'b0;
    rst_n = 1'b1;

    // First draw: edge k shifts ACE1->59C3 and enters DRAW; candidate 3 accepted
    req = 1'b1;
    tick();
    req = 1'b0;
    check("first_busy", if_a.busy, 1);
    lat = 1;
    while (!if_a.rnd_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_lat",       lat, 2);
    check("first_lat_range", (lat >= 2 && lat <= 17), 1);
    check("first_rnd",       if_a.rnd, 3);
    check("first_rnd_range", (if_a.rnd >= 1 && if_a.rnd <= 9), 1);
    check("first_timeout",   if_a.timeout, 0);
    check("first_b_rnd",     if_b.rnd, 3);
    tick();
    check("first_pulse_end", if_a.rnd_valid, 0);
    check("first_rnd_hold",  if_a.rnd, 3);

    // Seed 0005: candidates 10 (reject) then 4 (accept); dut_b times out
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    tick();
    check("seed5_lfsr", lfsr_a, 16'h0005);
    check("seed5_busy", if_a.busy, 0);
    seed_load = 1'b0;
    req       = 1'b1;
    tick();
    req = 1'b0;
    check("s5_busy_e1",  if_a.busy, 1);
    check("s5_state_e1", state_a, 1);
    check("s5_lfsr_e1",  lfsr_a, 16'h000A);
    check("s5_valid_e1", if_a.rnd_valid, 0);
    tick();
    check("s5_busy_e2",    if_a.busy, 1);
    check("s5_valid_e2",   if_a.rnd_valid, 0);
    check("s5_b_valid",    if_b.rnd_valid, 1);
    check("s5_b_timeout",  if_b.timeout, 1);
    check("s5_b_rnd",      if_b.rnd, 1);
    check("s5_b_busy",     if_b.busy, 0);
    tick();
    check("s5_valid_e3",   if_a.rnd_valid, 1);
    check("s5_rnd_e3",     if_a.rnd, 4);
    check("s5_timeout_e3", if_a.timeout, 0);
    check("s5_busy_e3",    if_a.busy, 0);
    check("s5_b_pulse_end", if_b.rnd_valid, 0);
    tick();
    check("s5_pulse_end", if_a.rnd_valid, 0);
    check("s5_rnd_hold",  if_a.rnd, 4);

    // seed_load during DRAW aborts without a result
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    tick();
    seed_load = 1'b0;
    req       = 1'b1;
    tick();
    check("abort_busy_pre", if_a.busy, 1);
    req       = 1'b0;
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    tick();
    check("abort_busy",    if_a.busy, 0);
    check("abort_valid",   if_a.rnd_valid, 0);
    check("abort_rnd",     if_a.rnd, 4);
    check("abort_lfsr",    lfsr_a, 16'h1234);
    check("abort_b_valid", if_b.rnd_valid, 0);
    check("abort_b_rnd",   if_b.rnd, 1);
    seed_load = 1'b0;
    tick();
    check("abort_valid_late", if_a.rnd_valid, 0);
    check("abort_rnd_late",   if_a.rnd, 4);

    // seed_load wins over req in IDLE
    seed_load = 1'b1;
    seed_in   = 16'h0005;
    req       = 1'b1;
    tick();
    check("prio_busy",  if_a.busy, 0);
    check("prio_state", state_a, 0);
    seed_load = 1'b0;
    req       = 1'b0;

    // Reset mid-draw discards the draw
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rstmid_busy_pre", if_a.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy",  if_a.busy, 0);
    check("rstmid_state", state_a, 0);
    check("rstmid_lfsr",  lfsr_a, 16'hACE1);
    check("rstmid_rnd",   if_a.rnd, 0);
    check("rstmid_valid", if_a.rnd_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_valid", if_a.rnd_valid, 0);
    end

    // Zero seed substitutes SEED; full period with no zero state
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("zero_seed_lfsr", lfsr_a, 16'hACE1);
    zero_seen = 0;
    first_ret = 0;
    step1     = 16'h0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i == 1) step1 = lfsr_a;
      if (lfsr_a == 16'h0) zero_seen++;
      if (lfsr_a == 16'hACE1 && first_ret == 0) first_ret = i;
    end
    check("lfsr_step1",   step1, 16'h59C3);
    check("lfsr_no_zero", zero_seen, 0);
    check("lfsr_period",  first_ret, 65535);

    // req held high: back-to-back draws, single-cycle pulses, full coverage
    req        = 1'b1;
    draws      = 0;
    cyc        = 0;
    prev_valid = 1'b0;
    seen       = 16'h0;
    while (draws < 1000 && cyc < 20000) begin
      tick();
      cyc++;
      if (prev_valid) begin
        check("b2b_pulse_single", if_a.rnd_valid, 0);
        check("b2b_busy_next",    if_a.busy, 1);
      end
      if (if_a.rnd_valid) begin
        draws++;
        check("b2b_rnd_range", (if_a.rnd >= 1 && if_a.rnd <= 9), 1);
        seen[if_a.rnd] = 1'b1;
      end
      prev_valid = if_a.rnd_valid;
    end
    req = 1'b0;
    check("b2b_draw_count", draws, 1000);
    check("b2b_all_values", seen, 16'h03FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
